// File: rtl/count_bcd_reader.sv
// Samples a 16-bit timer count, converts it to 5-digit BCD by sequential double-dabble
// (one bit per clock) and drives five active-low 7-segment digits plus terminal-count flags.

module count_bcd_nib (
  input  logic [3:0] scr,
  input  logic [3:0] dsp,
  output logic [3:0] adj,
  output logic [6:0] seg
);
  assign adj = (scr >= 4'd5) ? scr + 4'd3 : scr;

  // segments {g,f,e,d,c,b,a}, active low; non-decimal codes blank the digit
  always_comb begin
    seg = 7'b1111111;
    case (dsp)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module count_bcd_reader #(
  parameter logic [15:0] MAXCOUNT    = 16'd35264,
  parameter logic        AUTO_SAMPLE = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] count,
  input  logic        sample,
  output logic        busy,
  output logic        valid,
  output logic [19:0] bcd,
  output logic [6:0]  hex4,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic        at_max,
  output logic        over
);
  localparam int NUM_DIG = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                     state_q, state_d;
  logic [15:0]                bin_q, bin_d;
  logic [NUM_DIG-1:0][3:0]    scr_q, scr_d;
  logic [NUM_DIG-1:0][3:0]    bcd_q, bcd_d;
  logic [3:0]                 iter_q, iter_d;
  logic                       valid_q, valid_d;
  logic                       at_max_q, at_max_d;
  logic                       over_q, over_d;
  logic                       pmax_q, pmax_d;
  logic                       pover_q, pover_d;

  logic [NUM_DIG-1:0][3:0]    scr_adj;
  logic [NUM_DIG-1:0][6:0]    seg;

  genvar g;
  generate
    for (g = 0; g < NUM_DIG; g++) begin : g_dig
      count_bcd_nib u_nib (
        .scr (scr_q[g]),
        .dsp (bcd_q[g]),
        .adj (scr_adj[g]),
        .seg (seg[g])
      );
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    scr_d    = scr_q;
    iter_d   = iter_q;
    bcd_d    = bcd_q;
    valid_d  = 1'b0;
    at_max_d = at_max_q;
    over_d   = over_q;
    pmax_d   = pmax_q;
    pover_d  = pover_q;
    case (state_q)
      IDLE: begin
        if (sample || AUTO_SAMPLE) begin
          bin_d   = count;
          scr_d   = '0;
          iter_d  = '0;
          // flags are decided at the sampling edge since bin is shifted away
          pmax_d  = (count == MAXCOUNT);
          pover_d = (count > MAXCOUNT);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, bin_d} = {scr_adj, bin_q} << 1;
        iter_d         = iter_q + 4'd1;
        if (iter_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        bcd_d    = scr_q;
        at_max_d = pmax_q;
        over_d   = pover_q;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      scr_q    <= '0;
      iter_q   <= '0;
      bcd_q    <= '0;
      valid_q  <= 1'b0;
      at_max_q <= 1'b0;
      over_q   <= 1'b0;
      pmax_q   <= 1'b0;
      pover_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      scr_q    <= scr_d;
      iter_q   <= iter_d;
      bcd_q    <= bcd_d;
      valid_q  <= valid_d;
      at_max_q <= at_max_d;
      over_q   <= over_d;
      pmax_q   <= pmax_d;
      pover_q  <= pover_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign valid  = valid_q;
  assign bcd    = bcd_q;
  assign at_max = at_max_q;
  assign over   = over_q;
  assign hex0   = seg[0];
  assign hex1   = seg[1];
  assign hex2   = seg[2];
  assign hex3   = seg[3];
  assign hex4   = seg[4];
endmodule
